// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared definitions for the pipelined ripple adder: segment arithmetic,
// configuration sanity check and the per-stage control record.
package pipelined_ripple_adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SEG_W = 8;

   // Number of ripple segments, which is also the number of pipeline stages.
   function automatic int seg_count(input int width, input int seg_w);
      return width / seg_w;
   endfunction

   // A legal configuration splits the word into whole segments.
   function automatic bit width_ok(input int width, input int seg_w);
      return (seg_w > 0) && (seg_w <= width) && ((width % seg_w) == 0);
   endfunction

   // Control part of a stage record. The width-dependent data fields
   // (partial sum, remaining operands) are added by the parent module.
   typedef struct packed {
      logic valid;   // stage holds a real beat
      logic carry;   // carry out of this stage's segment
      logic ovf;     // signed overflow; meaningful in the last stage only
      logic sub;     // beat is a subtraction
   } stage_ctl_t;

endpackage

// File: rtl/seg_ripple_adder.sv
// Combinational SEG_W-bit ripple adder. Also exposes the carry into the
// segment MSB so the top segment can form the signed-overflow flag.
module seg_ripple_adder #(
   parameter int SEG_W = 8
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin,
   output logic [SEG_W-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [SEG_W:0] c_chain;

   // Bit-by-bit ripple: each full adder's carry feeds the next bit.
   always_comb begin
      c_chain    = '0;
      sum        = '0;
      c_chain[0] = cin;
      for (int i = 0; i < SEG_W; i++) begin
         sum[i]         = a[i] ^ b[i] ^ c_chain[i];
         c_chain[i + 1] = (a[i] & b[i]) | (c_chain[i] & (a[i] ^ b[i]));
      end
   end

   assign cout  = c_chain[SEG_W];
   assign c_msb = c_chain[SEG_W - 1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined carry-chain adder/subtractor. One register stage per SEG_W-bit
// segment, carry registered between stages, global stall on output backpressure.
module pipelined_ripple_adder
   import pipelined_ripple_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG_W = DEF_SEG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSEG = seg_count(WIDTH, SEG_W);

   if (!width_ok(WIDTH, SEG_W)) begin : g_bad_cfg
      $error("pipelined_ripple_adder: WIDTH must be a positive multiple of SEG_W");
   end

   typedef struct packed {
      stage_ctl_t       ctl;
      logic [WIDTH-1:0] psum;    // result bits produced so far
      logic [WIDTH-1:0] rem_a;   // operand A bits not yet consumed
      logic [WIDTH-1:0] rem_b;   // operand B bits (already inverted for subtract)
   } stage_t;

   stage_t st_q [NSEG];
   stage_t st_d [NSEG];
   stage_t src  [NSEG];   // record each stage loads when the pipe advances

   logic [NSEG-1:0][SEG_W-1:0] seg_sum;
   logic [NSEG-1:0]            seg_cout;
   logic [NSEG-1:0]            seg_cmsb;
   logic                       adv;

   assign out_valid = st_q[NSEG - 1].ctl.valid;
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;

   // Stage inputs: stage 0 takes the ports (subtract = A + ~B + 1), later stages the previous register.
   always_comb begin
      for (int k = 0; k < NSEG; k++) begin
         if (k == 0) begin
            src[k]           = '0;
            src[k].ctl.valid = in_valid && adv;
            src[k].ctl.carry = sub ? 1'b1 : cin;
            src[k].ctl.sub   = sub;
            src[k].rem_a     = a;
            src[k].rem_b     = sub ? ~b : b;
         end else begin
            src[k] = st_q[(k > 0) ? k - 1 : 0];
         end
      end
   end

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      seg_ripple_adder #(
         .SEG_W (SEG_W)
      ) u_seg (
         .a     (src[k].rem_a[k*SEG_W +: SEG_W]),
         .b     (src[k].rem_b[k*SEG_W +: SEG_W]),
         .cin   (src[k].ctl.carry),
         .sum   (seg_sum[k]),
         .cout  (seg_cout[k]),
         .c_msb (seg_cmsb[k])
      );
   end

   // Next stage contents: fold in this segment's result when advancing, otherwise hold.
   always_comb begin
      for (int k = 0; k < NSEG; k++) begin
         st_d[k] = st_q[k];
         if (adv) begin
            st_d[k]                         = src[k];
            st_d[k].ctl.carry               = seg_cout[k];
            st_d[k].ctl.ovf                 = seg_cout[k] ^ seg_cmsb[k];
            st_d[k].psum[k*SEG_W +: SEG_W]  = seg_sum[k];
            st_d[k].rem_a[k*SEG_W +: SEG_W] = '0;
            st_d[k].rem_b[k*SEG_W +: SEG_W] = '0;
         end
      end
   end

   // Stage registers; reset clears every stage so no in-flight beat survives.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NSEG; k++) begin
            st_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NSEG; k++) begin
            st_q[k] <= st_d[k];
         end
      end
   end

   assign sum  = st_q[NSEG - 1].psum;
   assign cout = st_q[NSEG - 1].ctl.carry;
   assign ovf  = st_q[NSEG - 1].ctl.ovf;

   // Operand leftovers and the sub flag are spent by the time a beat reaches the last stage.
   logic unused_tail;
   assign unused_tail = ^{st_q[NSEG - 1].rem_a, st_q[NSEG - 1].rem_b, st_q[NSEG - 1].ctl.sub};

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Randomized, model-checked bench for pipelined_ripple_adder (32/8 and 8/8 configurations).
module tb_pipelined_ripple_adder;

   localparam int W  = 32;
   localparam int SW = 8;
   localparam int NS = W / SW;

   typedef struct {
      longint sum;
      bit     cout;
      bit     ovf;
      int     acc_cyc;
      int     acc_stalls;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [W-1:0] a, b, sum;
   logic         in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
   logic [7:0]   a8, b8, sum8;

   pipelined_ripple_adder #(.WIDTH(W), .SEG_W(SW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   pipelined_ripple_adder #(.WIDTH(8), .SEG_W(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .cin       (cin8),
      .sub       (sub8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .sum       (sum8),
      .cout      (cout8),
      .ovf       (ovf8)
   );

   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc    = 0;
   int   stalls = 0;
   int   n_out  = 0;
   bit   mon_en = 0;
   exp_t exp_q[$];
   exp_t exp8;
   bit   pend8  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   // Arithmetic reference: plain integer add/subtract, signed range test for overflow.
   function automatic exp_t model(input longint ua, input longint ub, input bit c, input bit s, input int w);
      exp_t   r;
      longint m, half, sa, sb, ss, u;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = ua & m;
      ub   = ub & m;
      sa   = (ua >= half) ? ua - (m + 1) : ua;
      sb   = (ub >= half) ? ub - (m + 1) : ub;
      if (s) begin
         u      = ua - ub;
         r.cout = (ua >= ub);
         ss     = sa - sb;
      end else begin
         u      = ua + ub + longint'(c);
         r.cout = (u > m);
         ss     = sa + sb + longint'(c);
      end
      r.sum        = u & m;
      r.ovf        = (ss >= half) || (ss < -half);
      r.acc_cyc    = 0;
      r.acc_stalls = 0;
      return r;
   endfunction

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // 32-bit instance: scoreboard against the model, including exact latency with stalls.
   always @(negedge clk) begin : mon32
      exp_t e;
      cyc++;
      if (mon_en) begin
         if (!rst_n) begin
            exp_q.delete();
         end else begin
            if (exp_q.size() == 0) begin
               check("idle_out_valid", out_valid, 0);
               check("idle_in_ready", in_ready, 1);
            end else if (out_valid) begin
               check("stall_in_ready", in_ready, out_ready);
               check("sum", sum, exp_q[0].sum);
               check("cout", cout, exp_q[0].cout);
               check("ovf", ovf, exp_q[0].ovf);
               if (out_ready) begin
                  check("latency", cyc - exp_q[0].acc_cyc, NS + stalls - exp_q[0].acc_stalls);
                  void'(exp_q.pop_front());
                  n_out++;
               end else begin
                  stalls++;
               end
            end else begin
               check("busy_in_ready", in_ready, 1);
               check("not_overdue", (cyc - exp_q[0].acc_cyc) < (NS + stalls - exp_q[0].acc_stalls), 1);
            end
            if (in_valid && in_ready) begin
               e            = model(a, b, cin, sub, W);
               e.acc_cyc    = cyc;
               e.acc_stalls = stalls;
               exp_q.push_back(e);
            end
         end
      end
   end

   // 8-bit single-stage instance: result must appear exactly one cycle after acceptance.
   always @(negedge clk) begin : mon8
      if (mon_en) begin
         if (pend8) begin
            check("w8_out_valid", out_valid8, 1);
            check("w8_sum", sum8, exp8.sum);
            check("w8_cout", cout8, exp8.cout);
            check("w8_ovf", ovf8, exp8.ovf);
         end else begin
            check("w8_idle", out_valid8, 0);
         end
         check("w8_in_ready", in_ready8, 1);
         pend8 = rst_n && in_valid8 && in_ready8;
         if (pend8) exp8 = model(a8, b8, cin8, sub8, 8);
      end
   end

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
      int g;
      g        = 0;
      in_valid = 1;
      a        = ta;
      b        = tb;
      cin      = tc;
      sub      = ts;
      do begin
         @(negedge clk);
         g++;
      end while (!in_ready && g < 200);
      check("send_accept", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts,
                          input logic [W-1:0] esum, input logic ecout, input logic eovf);
      exp_t m;
      int   n;
      m = model(ta, tb, tc, ts, W);
      check({nm, "_model_sum"}, m.sum, esum);
      check({nm, "_model_cout"}, m.cout, ecout);
      check({nm, "_model_ovf"}, m.ovf, eovf);
      out_ready = 1;
      send(ta, tb, tc, ts);
      in_valid = 0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      check({nm, "_latency"}, n, NS);
      check({nm, "_sum"}, sum, esum);
      check({nm, "_cout"}, cout, ecout);
      check({nm, "_ovf"}, ovf, eovf);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      int g;
      in_valid  = 0;
      out_ready = 1;
      g = 0;
      while (exp_q.size() != 0 && g < 100) begin
         @(posedge clk);
         g++;
      end
      #1;
      check({nm, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int   n;
      int   n_before;
      exp_t m;

      rst_n = 0; in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 0;
      in_valid8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0; out_ready8 = 1;
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1;
      mon_en = 1;

      // Reset values
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Directed vectors
      run_vec("t1_wrap", 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0000_0000, 1, 0);
      run_vec("t2_pos_ovf", 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1);
      run_vec("t2_sub_ovf", 32'h8000_0000, 32'h1, 0, 1, 32'h7FFF_FFFF, 1, 1);
      run_vec("t3_sub_borrow", 32'h5, 32'h7, 1, 1, 32'hFFFF_FFFE, 0, 0);

      // Eight back-to-back beats; out_ready low across the 3rd..6th result cycles
      n_before = n_out;
      fork
         begin
            for (int i = 1; i <= 8; i++) send(i, 32'h100 * i, 0, 0);
            in_valid = 0;
         end
         begin
            for (int c = 1; c <= 20; c++) begin
               out_ready = !(c >= NS + 3 && c <= NS + 6);
               @(posedge clk);
               #1;
            end
            out_ready = 1;
         end
      join
      drain("t4");
      check("t4_count", n_out - n_before, 8);

      // Reset with three beats in flight and a fourth being offered
      out_ready = 1;
      send(32'h1, 32'h2, 0, 0);
      send(32'h3, 32'h4, 1, 0);
      send(32'h10, 32'h5, 0, 1);
      a     = 32'h99;
      rst_n = 0;
      @(posedge clk);
      #1;
      rst_n    = 1;
      in_valid = 0;
      @(negedge clk);
      check("t5_out_valid", out_valid, 0);
      check("t5_sum", sum, 0);
      check("t5_cout", cout, 0);
      check("t5_ovf", ovf, 0);
      @(posedge clk);
      #1;
      repeat (10) @(posedge clk);
      #1;
      run_vec("t5_after_rst", 32'h1234_5678, 32'h1111_1111, 0, 0, 32'h2345_6789, 0, 0);

      // Single-segment instance
      m = model(8'h80, 8'h7F, 1, 0, 8);
      check("t6_model_sum", m.sum, 0);
      check("t6_model_cout", m.cout, 1);
      check("t6_model_ovf", m.ovf, 0);
      in_valid8 = 1; a8 = 8'h80; b8 = 8'h7F; cin8 = 1; sub8 = 0;
      @(posedge clk);
      #1;
      in_valid8 = 0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid8 && n < 20);
      check("t6_latency", n, 1);
      check("t6_sum", sum8, 8'h00);
      check("t6_cout", cout8, 1);
      check("t6_ovf", ovf8, 0);
      @(posedge clk);
      #1;

      // Randomized traffic with backpressure and occasional reset
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         a         = rand_op();
         b         = rand_op();
         cin       = 1'($urandom_range(0, 1));
         sub       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid8 = 1'($urandom_range(0, 1));
         a8        = 8'($urandom);
         b8        = 8'($urandom);
         cin8      = 1'($urandom_range(0, 1));
         sub8      = 1'($urandom_range(0, 1));
         rst_n     = ($urandom_range(0, 149) != 0);
         @(posedge clk);
         #1;
      end
      rst_n     = 1;
      in_valid8 = 0;
      drain("rand");
      repeat (3) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
Parametrised, pipelined carry-chain adder/subtractor. The block splits the WIDTH-bit operation into NSEG = WIDTH/SEG_W ripple segments, with one register stage per segment and the carry registered between stages. It uses valid/ready handshakes on input and output, sustains one operation per cycle, and adds a subtract mode and a signed-overflow flag. It sits in the datapath wherever wide additions must close timing at clock rates a single ripple chain cannot meet.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of SEG_W.
SEG_W, 8, bits per ripple segment (one pipeline stage per segment); SEG_W ≤ WIDTH.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry in; ignored when sub=1.
sub  in  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accepts the result.
sum  out  WIDTH  result, modulo 2^WIDTH.
cout  out  1  carry out of the MSB; in sub mode, 1 means no borrow.
ovf  out  1  signed overflow = (carry into MSB) XOR (carry out of MSB).

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values (sampled with rst_n=0 at a clk edge):
  - all stage valid bits = 0, so out_valid = 0;
  - sum = 0, cout = 0, ovf = 0;
  - in_ready is 1 in the first cycle after reset.
- Reset mid-operation flushes all in-flight beats; none of them ever appear on the output.
- Stage k (0..NSEG-1) holds:
  - a valid bit;
  - the registered carry out of segment k;
  - the result bits [(k+1)*SEG_W-1:0];
  - the still-unprocessed upper operand bits;
  - the sub flag.
- Stage 0 adds segment 0 of a and b (b inverted when sub=1) with carry-in = sub ? 1 : cin.
- Stage k>0 adds segment k using the carry registered by stage k-1.
- Segment k uses only its own SEG_W bits plus one carry bit; there is no combinational carry path across stage registers.
- Stage NSEG-1 drives sum/cout/ovf directly from registers; there is no output combinational logic.
- The carry into the MSB, used for ovf, is computed inside the last segment.
- Global stall:
  - adv = !out_valid || out_ready;
  - in_ready = adv, combinational and independent of in_valid;
  - all stages shift together only when adv=1; when adv=0 every stage register holds its value.
- Stage 0 loads valid = in_valid && in_ready. Bubbles propagate as valid=0 stages.
- Latency: a beat accepted at edge t presents out_valid=1 from edge t+NSEG-1 onward, i.e. it is visible in the NSEG-th cycle after acceptance when there is no stall. With NSEG=1 the result is visible the cycle after acceptance.
- Throughput: 1 beat/cycle while out_ready=1. Ordering is strictly FIFO and no beat is dropped or duplicated.
- Output hold: while out_valid=1 and out_ready=0, sum/cout/ovf stay stable.
- Wrap-around: results are modulo 2^WIDTH. In add mode cout carries the overflow bit.
- Simultaneous events:
  - output handshake and new input in the same cycle: both complete, pipeline shifts.
  - rst_n=0 together with any handshake: reset wins, the beat is lost, and there is no output.

Decomposition:
- Shared package:
  - segment-count helper function (NSEG = WIDTH/SEG_W);
  - elaboration check that WIDTH % SEG_W == 0;
  - stage-record struct typedef {valid, carry, partial sum, remaining operands, sub}.
- One sub-module: seg_ripple_adder, a combinational SEG_W-bit ripple adder with outputs sum, cout, and carry-into-MSB. The parent instantiates it once per stage in a generate loop.

Test Plan:
1. WIDTH=32, SEG_W=8; a=0xFFFFFFFF, b=0x1, cin=0, sub=0, out_ready=1 -> sum=0x00000000, cout=1, ovf=0, out_valid in the 4th cycle after acceptance.
2. a=0x7FFFFFFF, b=0x1, sub=0 -> sum=0x80000000, cout=0, ovf=1; a=0x80000000, b=0x1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
3. sub=1, a=5, b=7, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0.
4. Eight back-to-back beats a=i, b=0x100*i (i=1..8), with out_ready low for cycles 3-6 -> the eight results appear in order with no loss; in_ready=0 exactly while out_valid=1 and out_ready=0; sum is held stable during the stall.
5. Three beats in flight, then rst_n=0 for one cycle -> out_valid=0, sum=0, cout=0, ovf=0 the next cycle; no stale result ever emerges; a new beat then completes normally.
6. WIDTH=8, SEG_W=8 (NSEG=1); a=0x80, b=0x7F, cin=1 -> sum=0x00, cout=1, ovf=0, one-cycle latency.
